branch_redirect_arbiter: RTL and testbench
==========================================

BRANCH_REDIRECT_ARBITER -- requirements
Module: branch_redirect_arbiter

Interface
REQ-001 Parameter ALU_NUM, default 4: number of ALU branch lanes arbitrated.
REQ-002 Parameter ROB_IDX_W, default 7: ROB index width (1 wrap bit at MSB + 6 index bits).
REQ-003 Parameter VADDR_W, default 32: redirect target width.
REQ-004 clk  input  1  single clock for all state.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 br_valid  input  ALU_NUM  per-lane branch result valid.
REQ-007 br_error  input  ALU_NUM  per-lane mispredict flag (qualified by br_valid).
REQ-008 br_robIdx  input  ALU_NUM x ROB_IDX_W  per-lane ROB index of the branch.
REQ-009 br_target  input  ALU_NUM x VADDR_W  per-lane corrected target.
REQ-010 redirect_valid  output  1  redirect request to frontend/ROB.
REQ-011 redirect_robIdx  output  ROB_IDX_W  ROB index of the redirecting branch.
REQ-012 redirect_target  output  VADDR_W  fetch restart address.
REQ-013 redirect_ack  input  1  consumer accepted redirect this cycle.
REQ-014 exc_flush  input  1  exception/full-pipeline flush from backend control.
REQ-015 walk_done  input  1  backend finished squash for the last accepted redirect.

Function
REQ-016 Candidate lane: br_valid & br_error; non-candidate lanes are ignored.
REQ-017 Age rule: a older than b if MSBs equal and a.idx < b.idx, or MSBs differ and a.idx > b.idx (wrap-around).
REQ-018 Same-cycle selection picks the oldest candidate; on identical robIdx, lowest lane number wins.
REQ-019 States: IDLE, HOLD (redirect presented), SQUASH (redirect accepted, awaiting walk_done).
REQ-020 IDLE: any candidate -> load selected robIdx/target into output registers, go HOLD; redirect_valid rises the next cycle (latency 1).
REQ-021 HOLD: redirect_valid=1; outputs stable unless replaced per REQ-022.
REQ-022 HOLD, no ack: selected candidate older than held entry replaces it next cycle; younger or equal discarded.
REQ-023 HOLD, ack: copy held robIdx to squash boundary register, go SQUASH, redirect_valid=0 next cycle.
REQ-024 HOLD, ack + same-cycle candidate older than held entry: load candidate, stay HOLD (new redirect next cycle), boundary updated to acked entry.
REQ-025 SQUASH: candidates younger than or equal to boundary dropped; older candidate -> load, go HOLD.
REQ-026 SQUASH, walk_done: go IDLE; a same-cycle candidate is handled as in IDLE (goes HOLD).
REQ-027 exc_flush in any state: go IDLE, redirect_valid=0 next cycle, same-cycle candidates discarded; overrides ack and walk_done.
REQ-028 redirect_robIdx/redirect_target change only on a load; hold last values otherwise.
REQ-029 At most one redirect outstanding; no output combinational path from br_* inputs.

Reset
REQ-030 rst asserted: state IDLE, redirect_valid=0, redirect_robIdx=0, redirect_target=0, boundary=0, effective immediately without clock.
REQ-031 First evaluation of inputs occurs on the first rising clk edge after rst deasserts; in-flight redirect lost.

Structure
REQ-032 Shared package holds ROB_IDX_W, VADDR_W, ALU_NUM defaults, state enum, and the robIdx age-compare function.
REQ-033 Sub-module oldest_select: combinational log2(ALU_NUM) tree returning valid, lane, robIdx, target of the oldest candidate.
REQ-034 Parameterised on ALU_NUM powers of two 1..8; expected 150-300 lines RTL.

Verification
REQ-035 Lanes 1 and 3 error, robIdx 0x05 and 0x03 -> next cycle redirect_valid=1, redirect_robIdx=0x03, target of lane 3.
REQ-036 Held 0x3E (MSB 0), lane 0 error robIdx 0x41 (wrapped, younger) -> discarded; lane 2 error 0x3A -> replaces held entry next cycle.
REQ-037 ack of 0x10, then SQUASH: error 0x12 dropped, error 0x0C -> HOLD with 0x0C; walk_done -> IDLE.
REQ-038 HOLD 0x20 with ack, exc_flush and older candidate 0x1F same cycle -> IDLE, redirect_valid=0, nothing loaded.
REQ-039 rst asserted mid-HOLD between edges -> redirect_valid=0 immediately; after release with no candidates stays 0.

Source files
------------

// File: rtl/branch_redirect_arbiter_pkg.sv
// Shared definitions for the branch redirect arbiter: default sizes, FSM
// state type and the wrap-aware ROB age comparison.
package branch_redirect_arbiter_pkg;

  localparam int unsigned ALU_NUM_DEF   = 4;
  localparam int unsigned ROB_IDX_W_DEF = 7;
  localparam int unsigned VADDR_W_DEF   = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } redir_state_e;

  // True when a is strictly older than b. The MSB of a w-bit index is the
  // wrap bit; differing wrap bits invert the sense of the index compare.
  function automatic logic rob_older(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input int unsigned w);
    logic [31:0] mask;
    logic [31:0] ia;
    logic [31:0] ib;
    mask = (32'd1 << (w - 1)) - 32'd1;
    ia   = a & mask;
    ib   = b & mask;
    if (a[w-1] == b[w-1]) return ia < ib;
    else                  return ia > ib;
  endfunction

endpackage

// File: rtl/branch_redirect_arbiter_oldest_select.sv
// Combinational tournament tree picking the oldest mispredicting lane;
// ties on robIdx resolve to the lowest lane number.
module branch_redirect_arbiter_oldest_select
  import branch_redirect_arbiter_pkg::*;
#(
  parameter int unsigned ALU_NUM   = ALU_NUM_DEF,
  parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int unsigned VADDR_W   = VADDR_W_DEF,
  parameter int unsigned LANE_W    = (ALU_NUM > 1) ? $clog2(ALU_NUM) : 1
) (
  input  logic [ALU_NUM-1:0]           br_valid,
  input  logic [ALU_NUM-1:0]           br_error,
  input  logic [ALU_NUM*ROB_IDX_W-1:0] br_robIdx,
  input  logic [ALU_NUM*VADDR_W-1:0]   br_target,
  output logic                         sel_valid_o,
  output logic [LANE_W-1:0]            sel_lane_o,
  output logic [ROB_IDX_W-1:0]         sel_robIdx_o,
  output logic [VADDR_W-1:0]           sel_target_o
);

  localparam int unsigned NODES = 2 * ALU_NUM - 1;

  logic                 nv [NODES];
  logic [LANE_W-1:0]    nl [NODES];
  logic [ROB_IDX_W-1:0] nr [NODES];
  logic [VADDR_W-1:0]   nt [NODES];

  // Heap layout: leaves sit at ALU_NUM-1.. in lane order, so a left child
  // always covers lower lane numbers and wins ties.
  always_comb begin
    int unsigned leaf;
    int unsigned n;
    int unsigned l;
    int unsigned r;
    logic        take_r;
    leaf   = 0;
    n      = 0;
    l      = 0;
    r      = 0;
    take_r = 1'b0;
    for (int unsigned i = 0; i < NODES; i++) begin
      nv[i] = 1'b0;
      nl[i] = '0;
      nr[i] = '0;
      nt[i] = '0;
    end
    for (int unsigned i = 0; i < ALU_NUM; i++) begin
      leaf     = ALU_NUM - 1 + i;
      nv[leaf] = br_valid[i] & br_error[i];
      nl[leaf] = LANE_W'(i);
      nr[leaf] = br_robIdx[i*ROB_IDX_W +: ROB_IDX_W];
      nt[leaf] = br_target[i*VADDR_W +: VADDR_W];
    end
    for (int unsigned k = 0; k + 1 < ALU_NUM; k++) begin
      n      = ALU_NUM - 2 - k;
      l      = 2 * n + 1;
      r      = 2 * n + 2;
      take_r = nv[r] && (!nv[l] ||
               rob_older(32'(nr[r]), 32'(nr[l]), ROB_IDX_W));
      nv[n]  = nv[l] | nv[r];
      nl[n]  = take_r ? nl[r] : nl[l];
      nr[n]  = take_r ? nr[r] : nr[l];
      nt[n]  = take_r ? nt[r] : nt[l];
    end
    sel_valid_o  = nv[0];
    sel_lane_o   = nl[0];
    sel_robIdx_o = nr[0];
    sel_target_o = nt[0];
  end

endmodule

// File: rtl/branch_redirect_arbiter.sv
// Arbitrates ALU branch mispredicts into a single registered redirect and
// tracks the squash boundary until the backend reports the walk is done.
module branch_redirect_arbiter
  import branch_redirect_arbiter_pkg::*;
#(
  parameter int unsigned ALU_NUM   = ALU_NUM_DEF,
  parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int unsigned VADDR_W   = VADDR_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ALU_NUM-1:0]           br_valid,
  input  logic [ALU_NUM-1:0]           br_error,
  input  logic [ALU_NUM*ROB_IDX_W-1:0] br_robIdx,
  input  logic [ALU_NUM*VADDR_W-1:0]   br_target,
  output logic                         redirect_valid,
  output logic [ROB_IDX_W-1:0]         redirect_robIdx,
  output logic [VADDR_W-1:0]           redirect_target,
  input  logic                         redirect_ack,
  input  logic                         exc_flush,
  input  logic                         walk_done
);

  localparam int unsigned LANE_W = (ALU_NUM > 1) ? $clog2(ALU_NUM) : 1;

  redir_state_e         state_q, state_d;
  logic [ROB_IDX_W-1:0] rob_q, rob_d;
  logic [VADDR_W-1:0]   tgt_q, tgt_d;
  logic [ROB_IDX_W-1:0] bnd_q, bnd_d;

  logic                 sel_valid;
  logic [LANE_W-1:0]    sel_lane_unused;
  logic [ROB_IDX_W-1:0] sel_rob;
  logic [VADDR_W-1:0]   sel_tgt;
  logic                 sel_older_held;
  logic                 sel_older_bnd;

  branch_redirect_arbiter_oldest_select #(
    .ALU_NUM  (ALU_NUM),
    .ROB_IDX_W(ROB_IDX_W),
    .VADDR_W  (VADDR_W),
    .LANE_W   (LANE_W)
  ) u_oldest_select (
    .br_valid    (br_valid),
    .br_error    (br_error),
    .br_robIdx   (br_robIdx),
    .br_target   (br_target),
    .sel_valid_o (sel_valid),
    .sel_lane_o  (sel_lane_unused),
    .sel_robIdx_o(sel_rob),
    .sel_target_o(sel_tgt)
  );

  assign sel_older_held = sel_valid && rob_older(32'(sel_rob), 32'(rob_q), ROB_IDX_W);
  assign sel_older_bnd  = sel_valid && rob_older(32'(sel_rob), 32'(bnd_q), ROB_IDX_W);

  always_comb begin
    state_d = state_q;
    rob_d   = rob_q;
    tgt_d   = tgt_q;
    bnd_d   = bnd_q;
    if (exc_flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sel_valid) begin
            rob_d   = sel_rob;
            tgt_d   = sel_tgt;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect_ack) begin
            bnd_d   = rob_q;
            state_d = ST_SQUASH;
          end
          if (sel_older_held) begin
            rob_d   = sel_rob;
            tgt_d   = sel_tgt;
            state_d = ST_HOLD;
          end
        end
        ST_SQUASH: begin
          // walk_done reopens arbitration, so the boundary no longer filters.
          if (walk_done) begin
            state_d = ST_IDLE;
            if (sel_valid) begin
              rob_d   = sel_rob;
              tgt_d   = sel_tgt;
              state_d = ST_HOLD;
            end
          end else if (sel_older_bnd) begin
            rob_d   = sel_rob;
            tgt_d   = sel_tgt;
            state_d = ST_HOLD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rob_q   <= '0;
      tgt_q   <= '0;
      bnd_q   <= '0;
    end else begin
      state_q <= state_d;
      rob_q   <= rob_d;
      tgt_q   <= tgt_d;
      bnd_q   <= bnd_d;
    end
  end

  assign redirect_valid  = (state_q == ST_HOLD);
  assign redirect_robIdx = rob_q;
  assign redirect_target = tgt_q;

endmodule

// File: tb/tb_branch_redirect_arbiter.sv
// Bench for branch_redirect_arbiter: directed scenarios plus a randomized
// run against a behavioural model built on modular ROB-distance arithmetic.
module tb_branch_redirect_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned RW = 7;
  localparam int unsigned VW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    br_valid;
  logic [N-1:0]    br_error;
  logic [N*RW-1:0] br_robIdx;
  logic [N*VW-1:0] br_target;
  logic            redirect_valid;
  logic [RW-1:0]   redirect_robIdx;
  logic [VW-1:0]   redirect_target;
  logic            redirect_ack;
  logic            exc_flush;
  logic            walk_done;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // model state
  bit          m_presented;
  bit          m_squashing;
  logic [RW-1:0] m_rob;
  logic [VW-1:0] m_tgt;
  logic [RW-1:0] m_bnd;

  branch_redirect_arbiter #(
    .ALU_NUM  (N),
    .ROB_IDX_W(RW),
    .VADDR_W  (VW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .br_valid       (br_valid),
    .br_error       (br_error),
    .br_robIdx      (br_robIdx),
    .br_target      (br_target),
    .redirect_valid (redirect_valid),
    .redirect_robIdx(redirect_robIdx),
    .redirect_target(redirect_target),
    .redirect_ack   (redirect_ack),
    .exc_flush      (exc_flush),
    .walk_done      (walk_done)
  );

  always #5 clk = ~clk;

  // a is older than b when b lies 1..half-window ahead of a modulo 2^RW.
  function automatic bit m_older(input int unsigned a, input int unsigned b);
    int unsigned d;
    d = (b - a) & ((1 << RW) - 1);
    return (d >= 1) && (d <= (1 << (RW - 1)) - 1);
  endfunction

  task automatic clear_inputs();
    br_valid     = '0;
    br_error     = '0;
    br_robIdx    = '0;
    br_target    = '0;
    redirect_ack = 1'b0;
    exc_flush    = 1'b0;
    walk_done    = 1'b0;
  endtask

  task automatic set_lane(input int unsigned lane, input logic [RW-1:0] rob,
                          input logic [VW-1:0] tgt);
    br_valid[lane]             = 1'b1;
    br_error[lane]             = 1'b1;
    br_robIdx[lane*RW +: RW]   = rob;
    br_target[lane*VW +: VW]   = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_mis++; $display("FAIL reset_valid got=%0b want=0", redirect_valid);
    end
    n_cmp++;
    if (redirect_robIdx !== 7'h00) begin
      n_mis++; $display("FAIL reset_rob got=%h want=00", redirect_robIdx);
    end
    n_cmp++;
    if (redirect_target !== 32'h0) begin
      n_mis++; $display("FAIL reset_target got=%h want=0", redirect_target);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_mis++; $display("FAIL reset_idle_valid got=%0b want=0", redirect_valid);
    end
  endtask

  task automatic test_oldest_select();
    do_reset();
    set_lane(1, 7'h05, 32'hBEEF_0001);
    set_lane(3, 7'h03, 32'hCAFE_0003);
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_mis++; $display("FAIL sel_no_comb_path got=%0b want=0", redirect_valid);
    end
    tick();
    clear_inputs();
    n_cmp++;
    if (redirect_valid !== 1'b1) begin
      n_mis++; $display("FAIL sel_valid got=%0b want=1", redirect_valid);
    end
    n_cmp++;
    if (redirect_robIdx !== 7'h03) begin
      n_mis++; $display("FAIL sel_rob got=%h want=03", redirect_robIdx);
    end
    n_cmp++;
    if (redirect_target !== 32'hCAFE_0003) begin
      n_mis++; $display("FAIL sel_target got=%h want=cafe0003", redirect_target);
    end
    do_reset();
    set_lane(0, 7'h22, 32'h0000_00A0);
    set_lane(2, 7'h22, 32'h0000_00A2);
    tick();
    clear_inputs();
    n_cmp++;
    if (redirect_target !== 32'h0000_00A0) begin
      n_mis++; $display("FAIL sel_tie_lowlane got=%h want=000000a0", redirect_target);
    end
  endtask

  task automatic test_replace();
    do_reset();
    set_lane(0, 7'h3E, 32'h0000_3E3E);
    tick();
    clear_inputs();
    set_lane(0, 7'h41, 32'h0000_4141);
    tick();
    clear_inputs();
    n_cmp++;
    if (redirect_robIdx !== 7'h3E || redirect_valid !== 1'b1) begin
      n_mis++; $display("FAIL replace_younger_kept got=%h want=3e", redirect_robIdx);
    end
    set_lane(2, 7'h3A, 32'h0000_3A3A);
    tick();
    clear_inputs();
    n_cmp++;
    if (redirect_robIdx !== 7'h3A) begin
      n_mis++; $display("FAIL replace_older_rob got=%h want=3a", redirect_robIdx);
    end
    n_cmp++;
    if (redirect_target !== 32'h0000_3A3A) begin
      n_mis++; $display("FAIL replace_older_target got=%h want=00003a3a", redirect_target);
    end
  endtask

  task automatic test_squash();
    do_reset();
    set_lane(1, 7'h10, 32'h0000_1010);
    tick();
    clear_inputs();
    redirect_ack = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_mis++; $display("FAIL squash_ack_valid got=%0b want=0", redirect_valid);
    end
    set_lane(3, 7'h12, 32'h0000_1212);
    tick();
    clear_inputs();
    n_cmp++;
    if (redirect_valid !== 1'b0 || redirect_robIdx !== 7'h10) begin
      n_mis++; $display("FAIL squash_younger_drop got=%0b/%h want=0/10", redirect_valid, redirect_robIdx);
    end
    set_lane(2, 7'h0C, 32'h0000_0C0C);
    tick();
    clear_inputs();
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_robIdx !== 7'h0C) begin
      n_mis++; $display("FAIL squash_older_load got=%0b/%h want=1/0c", redirect_valid, redirect_robIdx);
    end
    redirect_ack = 1'b1;
    tick();
    clear_inputs();
    walk_done = 1'b1;
    tick();
    clear_inputs();
    set_lane(0, 7'h50, 32'h0000_5050);
    tick();
    clear_inputs();
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_robIdx !== 7'h50) begin
      n_mis++; $display("FAIL squash_walk_idle got=%0b/%h want=1/50", redirect_valid, redirect_robIdx);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_lane(0, 7'h20, 32'h0000_2020);
    tick();
    clear_inputs();
    redirect_ack = 1'b1;
    exc_flush    = 1'b1;
    set_lane(1, 7'h1F, 32'h0000_1F1F);
    tick();
    clear_inputs();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_mis++; $display("FAIL flush_valid got=%0b want=0", redirect_valid);
    end
    n_cmp++;
    if (redirect_robIdx !== 7'h20) begin
      n_mis++; $display("FAIL flush_noload got=%h want=20", redirect_robIdx);
    end
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_mis++; $display("FAIL flush_stays_idle got=%0b want=0", redirect_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_lane(2, 7'h07, 32'h0000_0707);
    tick();
    clear_inputs();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (redirect_valid !== 1'b0 || redirect_robIdx !== 7'h00 || redirect_target !== 32'h0) begin
      n_mis++; $display("FAIL async_reset got=%0b/%h/%h want=0/00/0", redirect_valid, redirect_robIdx, redirect_target);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_mis++; $display("FAIL async_reset_release got=%0b want=0", redirect_valid);
    end
  endtask

  task automatic model_step();
    bit            found;
    logic [RW-1:0] b_rob;
    logic [VW-1:0] b_tgt;
    logic [RW-1:0] r;
    found = 1'b0;
    b_rob = '0;
    b_tgt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      r = br_robIdx[i*RW +: RW];
      if (br_valid[i] && br_error[i] && (!found || m_older(r, b_rob))) begin
        found = 1'b1;
        b_rob = r;
        b_tgt = br_target[i*VW +: VW];
      end
    end
    if (exc_flush) begin
      m_presented = 1'b0;
      m_squashing = 1'b0;
    end else if (m_presented) begin
      if (found && m_older(b_rob, m_rob)) begin
        if (redirect_ack) m_bnd = m_rob;
        m_rob = b_rob;
        m_tgt = b_tgt;
      end else if (redirect_ack) begin
        m_bnd       = m_rob;
        m_presented = 1'b0;
        m_squashing = 1'b1;
      end
    end else if (m_squashing) begin
      if (found && (walk_done || m_older(b_rob, m_bnd))) begin
        m_rob       = b_rob;
        m_tgt       = b_tgt;
        m_presented = 1'b1;
        m_squashing = 1'b0;
      end else if (walk_done) begin
        m_squashing = 1'b0;
      end
    end else if (found) begin
      m_rob       = b_rob;
      m_tgt       = b_tgt;
      m_presented = 1'b1;
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] base;
    do_reset();
    m_presented = 1'b0;
    m_squashing = 1'b0;
    m_rob       = '0;
    m_tgt       = '0;
    m_bnd       = '0;
    base        = 7'h00;
    for (int unsigned c = 0; c < 400; c++) begin
      clear_inputs();
      base = base + 7'($urandom_range(0, 5));
      for (int unsigned i = 0; i < N; i++) begin
        br_valid[i]           = ($urandom_range(0, 99) < 45);
        br_error[i]           = ($urandom_range(0, 99) < 50);
        br_robIdx[i*RW +: RW] = base + 7'($urandom_range(0, 40));
        br_target[i*VW +: VW] = $urandom;
      end
      redirect_ack = ($urandom_range(0, 99) < 40);
      walk_done    = ($urandom_range(0, 99) < 25);
      exc_flush    = ($urandom_range(0, 99) < 5);
      model_step();
      tick();
      n_cmp++;
      if (redirect_valid !== m_presented) begin
        n_mis++; $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", c, redirect_valid, m_presented);
      end
      n_cmp++;
      if (redirect_robIdx !== m_rob) begin
        n_mis++; $display("FAIL rand_rob cyc=%0d got=%h want=%h", c, redirect_robIdx, m_rob);
      end
      n_cmp++;
      if (redirect_target !== m_tgt) begin
        n_mis++; $display("FAIL rand_target cyc=%0d got=%h want=%h", c, redirect_target, m_tgt);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_oldest_select();
    test_replace();
    test_squash();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
